// File: rtl/lcd1602_ctrl_funcmod_if.sv
// Host-side write handshake for the LCD1602 controller: request, payload, completion and ready.
interface lcd1602_ctrl_funcmod_if;
   logic       call;
   logic       rs;
   logic [7:0] data;
   logic       done;
   logic       ready;

   modport master (output call, output rs, output data, input done, input ready);
   modport slave  (input call, input rs, input data, output done, output ready);
endinterface

// File: rtl/lcd1602_ctrl_funcmod.sv
// Write-only LCD1602 (HD44780) bus controller with 8-bit or 4-bit data bus.
// Define LCD1602_AUTO_INIT_EN to run the power-on instruction sequence before accepting requests.
module lcd1602_ctrl_funcmod #(
   parameter int unsigned POWERUP_CYC  = 1_000_000,
   parameter int unsigned EN_HALF_CYC  = 50_000,
   parameter int unsigned CMD_WAIT_CYC = 2_500,
   parameter int unsigned CLR_WAIT_CYC = 100_000,
   parameter int unsigned BUS_4BIT     = 0
) (
   input  logic       CLOCK,
   input  logic       RST_n,
   input  logic       iCall,
   input  logic       iRS,
   input  logic [7:0] iDATA,
   output logic       oDone,
   output logic       oReady,
   output logic       LCD1602_RS,
   output logic       LCD1602_RW,
   output logic       LCD1602_EN,
   output logic [7:0] LCD1602_D
);

   localparam int unsigned CNT_W = 20;
   localparam logic [CNT_W-1:0] PWR_LAST = CNT_W'(POWERUP_CYC - 1);
   localparam logic [CNT_W-1:0] EN_LAST  = CNT_W'(EN_HALF_CYC - 1);
   localparam logic [CNT_W-1:0] CMD_LAST = CNT_W'(CMD_WAIT_CYC - 1);
   localparam logic [CNT_W-1:0] CLR_LAST = CNT_W'(CLR_WAIT_CYC - 1);

   typedef enum logic [3:0] {
      PWRUP,
`ifdef LCD1602_AUTO_INIT_EN
      INIT,
`endif
      IDLE,
      SETUP,
      EN_HI,
      EN_LO,
      WAIT,
      DONE
   } state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [7:0]       byte_q, byte_d;
   logic             rs_q, rs_d;
   logic             nib_q, nib_d;
   logic             single_q, single_d;
   logic             lcd_rs_q, lcd_rs_d;
   logic [7:0]       lcd_d_q, lcd_d_d;
   logic             en_q, en_d;
   logic             done_q, done_d;
   logic             ready_q, ready_d;
   logic             counting;
   logic [CNT_W-1:0] wait_last;

`ifdef LCD1602_AUTO_INIT_EN
   localparam logic [3:0] INIT_LAST = (BUS_4BIT != 0) ? 4'd8 : 4'd4;
   logic       init_q, init_d;
   logic [3:0] idx_q, idx_d;

   // {single_nibble, byte} for each power-on instruction
   function automatic logic [8:0] init_rom(input logic [3:0] idx);
      logic [8:0] r;
      if (BUS_4BIT != 0) begin
         case (idx)
            4'd0, 4'd1, 4'd2: r = {1'b1, 8'h30};
            4'd3:             r = {1'b1, 8'h20};
            4'd4:             r = {1'b0, 8'h28};
            4'd5:             r = {1'b0, 8'h08};
            4'd6:             r = {1'b0, 8'h01};
            4'd7:             r = {1'b0, 8'h06};
            default:          r = {1'b0, 8'h0C};
         endcase
      end else begin
         case (idx)
            4'd0:    r = {1'b0, 8'h38};
            4'd1:    r = {1'b0, 8'h08};
            4'd2:    r = {1'b0, 8'h01};
            4'd3:    r = {1'b0, 8'h06};
            default: r = {1'b0, 8'h0C};
         endcase
      end
      return r;
   endfunction
`endif

   // Value placed on the pins for the current beat; 4-bit mode uses D[7:4] only
   function automatic logic [7:0] bus_byte(input logic [7:0] b, input logic second);
      logic [7:0] r;
      if (BUS_4BIT != 0) r = second ? {b[3:0], 4'h0} : {b[7:4], 4'h0};
      else               r = b;
      return r;
   endfunction

   assign counting  = (state_q == PWRUP) || (state_q == EN_HI) ||
                      (state_q == EN_LO) || (state_q == WAIT);
   assign wait_last = (!rs_q && (byte_q == 8'h01 || byte_q == 8'h02 || byte_q == 8'h03))
                      ? CLR_LAST : CMD_LAST;

   always_comb begin
      state_d  = state_q;
      byte_d   = byte_q;
      rs_d     = rs_q;
      nib_d    = nib_q;
      single_d = single_q;
`ifdef LCD1602_AUTO_INIT_EN
      init_d   = init_q;
      idx_d    = idx_q;
`endif
      case (state_q)
         PWRUP: begin
            if (cnt_q == PWR_LAST) begin
`ifdef LCD1602_AUTO_INIT_EN
               state_d = INIT;
               init_d  = 1'b1;
               idx_d   = 4'd0;
`else
               state_d = IDLE;
`endif
            end
         end
`ifdef LCD1602_AUTO_INIT_EN
         INIT: begin
            {single_d, byte_d} = init_rom(idx_q);
            rs_d    = 1'b0;
            nib_d   = 1'b0;
            state_d = SETUP;
         end
`endif
         IDLE: begin
            if (iCall) begin
               byte_d   = iDATA;
               rs_d     = iRS;
               nib_d    = 1'b0;
               single_d = 1'b0;
               state_d  = SETUP;
            end
         end
         SETUP: state_d = EN_HI;
         EN_HI: if (cnt_q == EN_LAST) state_d = EN_LO;
         EN_LO: begin
            if (cnt_q == EN_LAST) begin
               if ((BUS_4BIT != 0) && !nib_q && !single_q) begin
                  nib_d   = 1'b1;
                  state_d = SETUP;
               end else begin
                  state_d = WAIT;
               end
            end
         end
         WAIT: begin
            if (cnt_q == wait_last) begin
               state_d = DONE;
`ifdef LCD1602_AUTO_INIT_EN
               // Power-on instructions complete silently
               if (init_q) begin
                  if (idx_q == INIT_LAST) begin
                     init_d  = 1'b0;
                     state_d = IDLE;
                  end else begin
                     idx_d   = idx_q + 4'd1;
                     state_d = INIT;
                  end
               end
`endif
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = PWRUP;
      endcase

      cnt_d = (counting && (state_d == state_q)) ? cnt_q + CNT_W'(1) : '0;

      // Outputs are registered from the next state so pins align with state entry
      en_d     = (state_d == EN_HI);
      done_d   = (state_d == DONE);
      ready_d  = (state_d == IDLE) || (state_d == DONE);
      lcd_rs_d = lcd_rs_q;
      lcd_d_d  = lcd_d_q;
      if (state_d == SETUP) begin
         lcd_rs_d = rs_d;
         lcd_d_d  = bus_byte(byte_d, nib_d);
      end
   end

   always_ff @(posedge CLOCK or negedge RST_n) begin
      if (!RST_n) begin
         state_q  <= PWRUP;
         cnt_q    <= '0;
         byte_q   <= '0;
         rs_q     <= 1'b0;
         nib_q    <= 1'b0;
         single_q <= 1'b0;
         lcd_rs_q <= 1'b0;
         lcd_d_q  <= '0;
         en_q     <= 1'b0;
         done_q   <= 1'b0;
         ready_q  <= 1'b0;
`ifdef LCD1602_AUTO_INIT_EN
         init_q   <= 1'b0;
         idx_q    <= '0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         byte_q   <= byte_d;
         rs_q     <= rs_d;
         nib_q    <= nib_d;
         single_q <= single_d;
         lcd_rs_q <= lcd_rs_d;
         lcd_d_q  <= lcd_d_d;
         en_q     <= en_d;
         done_q   <= done_d;
         ready_q  <= ready_d;
`ifdef LCD1602_AUTO_INIT_EN
         init_q   <= init_d;
         idx_q    <= idx_d;
`endif
      end
   end

   assign oDone      = done_q;
   assign oReady     = ready_q;
   assign LCD1602_RS = lcd_rs_q;
   assign LCD1602_RW = 1'b0;
   assign LCD1602_EN = en_q;
   assign LCD1602_D  = lcd_d_q;

endmodule

// File: tb/tb_lcd1602_ctrl_funcmod.sv
// Scoreboard bench for lcd1602_ctrl_funcmod: 8-bit and 4-bit instances share clock and reset.
`timescale 1ns/1ps
module tb_lcd1602_ctrl_funcmod;
   localparam int unsigned PWR = 100;
   localparam int unsigned EH  = 4;
   localparam int unsigned CW  = 20;
   localparam int unsigned LW  = 50;

   typedef struct packed { logic rs; logic [7:0] d; } beat_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   lcd1602_ctrl_funcmod_if h8();
   lcd1602_ctrl_funcmod_if h4();

   logic       rs8, rw8, en8, rs4, rw4, en4;
   logic [7:0] d8, d4;

   lcd1602_ctrl_funcmod #(.POWERUP_CYC(PWR), .EN_HALF_CYC(EH), .CMD_WAIT_CYC(CW),
                          .CLR_WAIT_CYC(LW), .BUS_4BIT(0)) dut8 (
      .CLOCK(clk), .RST_n(rst_n), .iCall(h8.call), .iRS(h8.rs), .iDATA(h8.data),
      .oDone(h8.done), .oReady(h8.ready), .LCD1602_RS(rs8), .LCD1602_RW(rw8),
      .LCD1602_EN(en8), .LCD1602_D(d8));

   lcd1602_ctrl_funcmod #(.POWERUP_CYC(PWR), .EN_HALF_CYC(EH), .CMD_WAIT_CYC(CW),
                          .CLR_WAIT_CYC(LW), .BUS_4BIT(1)) dut4 (
      .CLOCK(clk), .RST_n(rst_n), .iCall(h4.call), .iRS(h4.rs), .iDATA(h4.data),
      .oDone(h4.done), .oReady(h4.ready), .LCD1602_RS(rs4), .LCD1602_RW(rw4),
      .LCD1602_EN(en4), .LCD1602_D(d4));

   int    checks = 0;
   int    errors = 0;
   beat_t exp8_q[$];
   beat_t exp4_q[$];

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({h8.ready, h8.done, en8, rs8, rw8, d8} !== 13'h0) begin
         errors++;
         $display("FAIL reset_state8 got=%h want=0", {h8.ready, h8.done, en8, rs8, rw8, d8});
      end
      checks++;
      if ({h4.ready, h4.done, en4, rs4, rw4, d4} !== 13'h0) begin
         errors++;
         $display("FAIL reset_state4 got=%h want=0", {h4.ready, h4.done, en4, rs4, rw4, d4});
      end
   endtask

   task automatic test_powerup();
      int k = 0;
      int en_seen = 0;
      rst_n = 1'b1;
      while (!h8.ready && k < 2000) begin
         @(posedge clk); k++; @(negedge clk);
         if (en8 || en4) en_seen++;
      end
      checks++;
      if (k != PWR) begin errors++; $display("FAIL powerup_latency got=%0d want=%0d", k, PWR); end
      checks++;
      if (h4.ready !== 1'b1) begin errors++; $display("FAIL powerup_ready4 got=%b want=1", h4.ready); end
      checks++;
      if (en_seen != 0) begin errors++; $display("FAIL powerup_en got=%0d want=0", en_seen); end
   endtask

   task automatic test_auto_init();
      int    k = 0;
      int    dn = 0;
      int    early = 0;
      logic  p8 = 1'b0, p4 = 1'b0;
      beat_t b;
      exp8_q = '{'{1'b0, 8'h38}, '{1'b0, 8'h08}, '{1'b0, 8'h01}, '{1'b0, 8'h06}, '{1'b0, 8'h0C}};
      exp4_q = '{'{1'b0, 8'h30}, '{1'b0, 8'h30}, '{1'b0, 8'h30}, '{1'b0, 8'h20},
                 '{1'b0, 8'h20}, '{1'b0, 8'h80}, '{1'b0, 8'h00}, '{1'b0, 8'h80},
                 '{1'b0, 8'h00}, '{1'b0, 8'h10}, '{1'b0, 8'h00}, '{1'b0, 8'h60},
                 '{1'b0, 8'h00}, '{1'b0, 8'hC0}};
      rst_n = 1'b1;
      while (!(h8.ready && h4.ready) && k < 4000) begin
         @(posedge clk); k++; @(negedge clk);
         if (h8.done || h4.done) dn++;
         if (k <= PWR && (en8 || en4 || h8.ready || h4.ready)) early++;
         if (en8 && !p8) begin
            checks++;
            if (exp8_q.size() == 0) begin errors++; $display("FAIL init8_extra got=%h", d8); end
            else begin
               b = exp8_q.pop_front();
               if ({rs8, d8} !== b) begin errors++; $display("FAIL init8_beat got=%h want=%h", {rs8, d8}, b); end
            end
         end
         if (en4 && !p4) begin
            checks++;
            if (exp4_q.size() == 0) begin errors++; $display("FAIL init4_extra got=%h", d4); end
            else begin
               b = exp4_q.pop_front();
               if ({rs4, d4} !== b) begin errors++; $display("FAIL init4_beat got=%h want=%h", {rs4, d4}, b); end
            end
         end
         p8 = en8; p4 = en4;
      end
      checks++;
      if (!(h8.ready && h4.ready)) begin errors++; $display("FAIL init_ready got=%b%b want=11", h8.ready, h4.ready); end
      checks++;
      if (exp8_q.size() + exp4_q.size() != 0) begin
         errors++; $display("FAIL init_missing got=%0d want=0", exp8_q.size() + exp4_q.size());
      end
      checks++;
      if (dn != 0) begin errors++; $display("FAIL init_done got=%0d want=0", dn); end
      checks++;
      if (early != 0) begin errors++; $display("FAIL init_pwrup got=%0d want=0", early); end
      exp8_q.delete(); exp4_q.delete();
   endtask

   task automatic test_data_write();
      int    k = 0;
      int    hi = 0;
      int    rises = 0;
      logic  pe = 1'b0;
      beat_t b;
      exp8_q.push_back('{1'b1, 8'h41});
      h8.rs = 1'b1; h8.data = 8'h41; h8.call = 1'b1;
      @(posedge clk); @(negedge clk);
      h8.call = 1'b0; h8.data = 8'h00;
      checks++;
      if (h8.ready !== 1'b0) begin errors++; $display("FAIL data_ready_drop got=%b want=0", h8.ready); end
      while (k < 500) begin
         if (en8) hi++;
         if (en8 && !pe) begin
            rises++;
            checks++;
            if (exp8_q.size() == 0) begin errors++; $display("FAIL data_extra got=%h", d8); end
            else begin
               b = exp8_q.pop_front();
               if ({rs8, d8} !== b) begin errors++; $display("FAIL data_beat got=%h want=%h", {rs8, d8}, b); end
            end
         end
         pe = en8;
         if (h8.done) break;
         @(posedge clk); k++; @(negedge clk);
      end
      checks++;
      if (k != 1 + (2 * EH + 1) - 1 + CW) begin errors++; $display("FAIL data_latency got=%0d want=29", k); end
      checks++;
      if (h8.ready !== 1'b1) begin errors++; $display("FAIL data_ready_rise got=%b want=1", h8.ready); end
      checks++;
      if (hi != EH || rises != 1) begin errors++; $display("FAIL data_en got=%0d/%0d want=4/1", hi, rises); end
      @(posedge clk); @(negedge clk);
      checks++;
      if (h8.done !== 1'b0) begin errors++; $display("FAIL data_done_width got=%b want=0", h8.done); end
      repeat (5) @(negedge clk);
      checks++;
      if ({h8.ready, rs8, d8} !== {1'b1, 1'b1, 8'h41}) begin
         errors++; $display("FAIL data_idle_hold got=%h want=141", {h8.ready, rs8, d8});
      end
   endtask

   task automatic test_clear_busy();
      int    k = 0;
      int    rises = 0;
      int    extra = 0;
      logic  pe = 1'b0;
      beat_t b;
      exp8_q.push_back('{1'b0, 8'h01});
      h8.rs = 1'b0; h8.data = 8'h01; h8.call = 1'b1;
      @(posedge clk); @(negedge clk);
      h8.data = 8'hFF; h8.rs = 1'b1;
      while (k < 500) begin
         if (en8 && !pe) begin
            rises++;
            checks++;
            if (exp8_q.size() == 0) begin errors++; $display("FAIL clear_extra got=%h", d8); end
            else begin
               b = exp8_q.pop_front();
               if ({rs8, d8} !== b) begin errors++; $display("FAIL clear_beat got=%h want=%h", {rs8, d8}, b); end
            end
         end
         pe = en8;
         if (h8.done) break;
         @(posedge clk); k++; @(negedge clk);
      end
      h8.call = 1'b0;
      checks++;
      if (k != 1 + (2 * EH + 1) - 1 + LW) begin errors++; $display("FAIL clear_latency got=%0d want=59", k); end
      repeat (30) begin
         @(posedge clk); @(negedge clk);
         if (en8 && !pe) extra++;
         if (!h8.ready) extra++;
         pe = en8;
      end
      checks++;
      if (rises != 1 || extra != 0) begin errors++; $display("FAIL busy_ignore got=%0d/%0d want=1/0", rises, extra); end
   endtask

   task automatic test_4bit();
      int    k = 0;
      int    hi = 0;
      int    rises = 0;
      logic  pe = 1'b0;
      beat_t b;
      exp4_q.push_back('{1'b1, 8'hA0});
      exp4_q.push_back('{1'b1, 8'h50});
      h4.rs = 1'b1; h4.data = 8'hA5; h4.call = 1'b1;
      @(posedge clk); @(negedge clk);
      h4.call = 1'b0;
      while (k < 500) begin
         if (en4) hi++;
         if (en4 && !pe) begin
            rises++;
            checks++;
            if (exp4_q.size() == 0) begin errors++; $display("FAIL nib_extra got=%h", d4); end
            else begin
               b = exp4_q.pop_front();
               if ({rs4, d4} !== b) begin errors++; $display("FAIL nib_beat got=%h want=%h", {rs4, d4}, b); end
            end
         end
         pe = en4;
         if (h4.done) break;
         @(posedge clk); k++; @(negedge clk);
      end
      checks++;
      if (k != 1 + 2 * (2 * EH + 1) - 1 + CW) begin errors++; $display("FAIL nib_latency got=%0d want=38", k); end
      checks++;
      if (hi != 2 * EH || rises != 2) begin errors++; $display("FAIL nib_en got=%0d/%0d want=8/2", hi, rises); end
      checks++;
      if (exp4_q.size() != 0) begin errors++; $display("FAIL nib_missing got=%0d want=0", exp4_q.size()); end
   endtask

   task automatic test_reset_mid();
      int k = 0;
      int en_seen = 0;
      h8.rs = 1'b1; h8.data = 8'h55; h8.call = 1'b1;
      @(posedge clk); @(negedge clk);
      h8.call = 1'b0;
      while (!en8 && k < 20) begin @(posedge clk); k++; @(negedge clk); end
      checks++;
      if (en8 !== 1'b1) begin errors++; $display("FAIL mid_en_start got=%b want=1", en8); end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({en8, h8.ready, h8.done, d8} !== 11'h0) begin
         errors++; $display("FAIL mid_abort got=%h want=0", {en8, h8.ready, h8.done, d8});
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      k = 0;
      while (!h8.ready && k < 4000) begin
         @(posedge clk); k++; @(negedge clk);
         if (k < PWR && en8) en_seen++;
      end
      checks++;
      if (en_seen != 0) begin errors++; $display("FAIL mid_pwrup_en got=%0d want=0", en_seen); end
`ifdef LCD1602_AUTO_INIT_EN
      checks++;
      if (k <= PWR || !h8.ready) begin errors++; $display("FAIL mid_restart got=%0d want>%0d", k, PWR); end
`else
      checks++;
      if (k != PWR) begin errors++; $display("FAIL mid_restart got=%0d want=%0d", k, PWR); end
`endif
   endtask

   initial begin
      h8.call = 1'b0; h8.rs = 1'b0; h8.data = 8'h00;
      h4.call = 1'b0; h4.rs = 1'b0; h4.data = 8'h00;
      test_reset();
`ifdef LCD1602_AUTO_INIT_EN
      test_auto_init();
`else
      test_powerup();
`endif
      test_data_write();
      test_clear_busy();
      test_4bit();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1);
   end

endmodule
